// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared Montgomery multiplier widths, modulus constants and state type
package mont_pkg;

  localparam int SIZE_INPUT = 2048;
  localparam int WORD_SIZE  = 64;
  localparam int ITERATION  = SIZE_INPUT / WORD_SIZE;
  localparam int WW         = WORD_SIZE + $clog2(ITERATION);

  // Every word nonzero, LSW = 1 (so N' = -N^-1 mod 2^64 is all ones), MSB set.
  function automatic logic [SIZE_INPUT-1:0] gen_modulus();
    logic [SIZE_INPUT-1:0] r;
    r = '0;
    for (int i = 0; i < ITERATION; i++) begin
      r[i*WORD_SIZE +: WORD_SIZE] = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
    end
    r[WORD_SIZE-1:0] = 64'd1;
    r[SIZE_INPUT-1]  = 1'b1;
    return r;
  endfunction

  localparam logic [SIZE_INPUT-1:0] MONT_N       = gen_modulus();
  localparam logic [WORD_SIZE-1:0]  MONT_N_PRIME = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_U,
    ST_LOAD_V,
    ST_EVAL,
    ST_PRESENT
  } mont_state_e;

endpackage

// File: rtl/mont_word_cmp.sv
// rtl/mont_word_cmp.sv - LSW-first running "operand < modulus" flag, updated one word per beat
module mont_word_cmp
  import mont_pkg::*;
#(
  parameter int W = WORD_SIZE
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] word,
  input  logic [W-1:0] n_word,
  output logic         lt
);

  // A higher word overrides any verdict from lower words; equal words keep it.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lt <= 1'b0;
    end else if (en) begin
      if (word < n_word) begin
        lt <= 1'b1;
      end else if (word > n_word) begin
        lt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mont_operand_loader.sv
// rtl/mont_operand_loader.sv - word-serial u/v loader with on-the-fly range check and word-sum weights
module mont_operand_loader
  import mont_pkg::*;
#(
  parameter int                     SIZE_INPUT = mont_pkg::SIZE_INPUT,
  parameter int                     WORD_SIZE  = mont_pkg::WORD_SIZE,
  parameter logic [SIZE_INPUT-1:0]  N          = MONT_N,
  localparam int                    ITERATION  = SIZE_INPUT / WORD_SIZE,
  localparam int                    WW         = WORD_SIZE + $clog2(ITERATION)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_SIZE-1:0]  in_data,
  input  logic                  in_last,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [SIZE_INPUT-1:0] op_u,
  output logic [SIZE_INPUT-1:0] op_v,
  output logic [WW-1:0]         op_wu,
  output logic [WW-1:0]         op_wv,
  output logic                  range_err,
  output logic                  frame_err
);

  localparam int WCW = $clog2(2 * ITERATION);

  mont_state_e           state;
  logic [WCW-1:0]        wc;
  logic [WCW-2:0]        widx;
  logic [SIZE_INPUT-1:0] u_reg;
  logic [SIZE_INPUT-1:0] v_reg;
  logic [WW-1:0]         wu;
  logic [WW-1:0]         wv;
  logic [WORD_SIZE-1:0]  n_word;
  logic [WW-1:0]         data_ext;
  logic                  beat;
  logic                  last_idx;
  logic                  bad_last;
  logic                  restart;
  logic                  lt_u;
  logic                  lt_v;

  assign in_ready = (state == ST_LOAD_U) || (state == ST_LOAD_V);
  assign beat     = in_valid && in_ready;
  assign widx     = wc[WCW-2:0];
  assign last_idx = (wc == WCW'(2 * ITERATION - 1));
  assign bad_last = (in_last != last_idx);
  assign n_word   = N[widx*WORD_SIZE +: WORD_SIZE];
  assign data_ext = {{(WW - WORD_SIZE){1'b0}}, in_data};

  // Any path back to word 0 must also reset the range flags.
  assign restart = (state == ST_IDLE)
                || (state == ST_EVAL)
                || ((state == ST_PRESENT) && op_ready)
                || (beat && bad_last);

  mont_word_cmp #(.W(WORD_SIZE)) u_cmp_u (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart),
    .en     (beat && (state == ST_LOAD_U)),
    .word   (in_data),
    .n_word (n_word),
    .lt     (lt_u)
  );

  mont_word_cmp #(.W(WORD_SIZE)) u_cmp_v (
    .clk    (clk),
    .reset  (reset),
    .clear  (restart),
    .en     (beat && (state == ST_LOAD_V)),
    .word   (in_data),
    .n_word (n_word),
    .lt     (lt_v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      wc        <= '0;
      u_reg     <= '0;
      v_reg     <= '0;
      wu        <= '0;
      wv        <= '0;
      op_valid  <= 1'b0;
      range_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      range_err <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= ST_LOAD_U;
        end
        ST_LOAD_U, ST_LOAD_V: begin
          if (beat) begin
            if (bad_last) begin
              frame_err <= 1'b1;
              state     <= ST_LOAD_U;
              wc        <= '0;
              wu        <= '0;
              wv        <= '0;
            end else begin
              wc <= wc + 1'b1;
              if (state == ST_LOAD_U) begin
                u_reg[widx*WORD_SIZE +: WORD_SIZE] <= in_data;
                wu <= wu + data_ext;
                if (widx == '1) begin
                  state <= ST_LOAD_V;
                end
              end else begin
                v_reg[widx*WORD_SIZE +: WORD_SIZE] <= in_data;
                wv <= wv + data_ext;
                if (last_idx) begin
                  state <= ST_EVAL;
                end
              end
            end
          end
        end
        ST_EVAL: begin
          if (lt_u && lt_v) begin
            state    <= ST_PRESENT;
            op_valid <= 1'b1;
          end else begin
            range_err <= 1'b1;
            state     <= ST_LOAD_U;
            wc        <= '0;
            wu        <= '0;
            wv        <= '0;
          end
        end
        ST_PRESENT: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= ST_LOAD_U;
            wc       <= '0;
            wu       <= '0;
            wv       <= '0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          op_valid <= 1'b0;
        end
      endcase
    end
  end

  assign op_u  = u_reg;
  assign op_v  = v_reg;
  assign op_wu = wu;
  assign op_wv = wv;

endmodule

// File: tb/tb_mont_operand_loader.sv
// tb/tb_mont_operand_loader.sv - randomized frame-level bench with an operand/event reference model
module tb_mont_operand_loader;
  import mont_pkg::*;

  localparam int K_ACC   = 0;
  localparam int K_RANGE = 1;
  localparam int K_FRAME = 2;

  typedef struct {
    int            kind;
    int            cyc;
    logic [2047:0] u;
    logic [2047:0] v;
    logic [68:0]   wu;
    logic [68:0]   wv;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          in_last = 1'b0;
  logic          op_valid;
  logic          op_ready = 1'b0;
  logic [2047:0] op_u;
  logic [2047:0] op_v;
  logic [68:0]   op_wu;
  logic [68:0]   op_wv;
  logic          range_err;
  logic          frame_err;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  opr_mode = 1;
  ev_t exp_q[$];
  ev_t held;
  bit  prev_ov = 1'b0;
  bit  hs = 1'b0;
  logic [63:0] fw [64];

  mont_operand_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_u      (op_u),
    .op_v      (op_v),
    .op_wu     (op_wu),
    .op_wv     (op_wv),
    .range_err (range_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (opr_mode)
      1:       op_ready = 1'b1;
      2:       op_ready = 1'b0;
      default: op_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_wide(input string name, input logic [2047:0] act, input logic [2047:0] req);
    int idx;
    idx = -1;
    for (int i = 31; i >= 0; i--) begin
      if (act[i*64 +: 64] !== req[i*64 +: 64]) idx = i;
    end
    n_cmp++;
    if (idx >= 0) begin
      n_bad++;
      $display("FAIL %s: word %0d actual %h required %h (cycle %0d)", name, idx,
               act[idx*64 +: 64], req[idx*64 +: 64], cyc);
    end
  endtask

  task automatic expect_ev(input int kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_event: actual kind %0d required none (cycle %0d)", kind, cyc);
    end else begin
      ev = exp_q.pop_front();
      chk("event_kind", kind, ev.kind);
      chk("event_cycle", cyc, ev.cyc);
      if (kind == K_ACC && ev.kind == K_ACC) begin
        chk_wide("op_u", op_u, ev.u);
        chk_wide("op_v", op_v, ev.v);
        chk("op_wu", op_wu, ev.wu);
        chk("op_wv", op_wv, ev.wv);
        held = ev;
      end
    end
  endtask

  // Compare process: every event the model predicts must appear on its cycle, and nothing else.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
      hs      = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missing_event: actual none required kind %0d at cycle %0d", exp_q[0].kind, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (prev_ov) begin
        if (hs) begin
          chk("op_valid_drop", op_valid, 1'b0);
        end else begin
          chk("op_valid_hold", op_valid, 1'b1);
          chk_wide("op_u_stable", op_u, held.u);
          chk_wide("op_v_stable", op_v, held.v);
          chk("op_w_stable", {op_wu, op_wv}, {held.wu, held.wv});
        end
      end
      if (op_valid) chk("in_ready_while_present", in_ready, 1'b0);
      if (op_valid && !prev_ov) expect_ev(K_ACC);
      if (range_err) expect_ev(K_RANGE);
      if (frame_err) expect_ev(K_FRAME);
      prev_ov = op_valid;
      hs      = op_valid && op_ready;
    end
  end

  task automatic load_frame(input logic [2047:0] u, input logic [2047:0] v);
    for (int k = 0; k < 32; k++) begin
      fw[k]      = u[k*64 +: 64];
      fw[k + 32] = v[k*64 +: 64];
    end
  endtask

  function automatic logic [2047:0] rand_wide();
    logic [2047:0] r;
    for (int k = 0; k < 64; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [2047:0] rand_below_n();
    logic [2047:0] r;
    r = rand_wide();
    r[2047:1984] = MONT_N[2047:1984] >> 1;
    return r;
  endfunction

  // bad < 0: legal frame; bad = k: framing error on beat k (k = 63 means in_last missing).
  task automatic send_frame(input int bad, input int stop_after, input bit gaps);
    int            t;
    ev_t           ev;
    logic [2047:0] mu;
    logic [2047:0] mv;
    ev = '{kind: 0, cyc: 0, u: '0, v: '0, wu: '0, wv: '0};
    for (int k = 0; k < 64; k++) begin
      if (k == stop_after) begin
        in_valid = 1'b0;
        return;
      end
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = fw[k];
      in_last  = (bad < 0) ? (k == 63) : (bad != 63 && k == bad);
      t = 0;
      while (!in_ready && t < 3000) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat_timeout: actual in_ready 0 required 1 (beat %0d)", k);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (k == bad) begin
        ev.kind = K_FRAME;
        ev.cyc  = cyc;
        exp_q.push_back(ev);
        return;
      end
    end
    mu = '0;
    mv = '0;
    for (int k = 0; k < 32; k++) begin
      mu[k*64 +: 64] = fw[k];
      mv[k*64 +: 64] = fw[k + 32];
      ev.wu += 69'(fw[k]);
      ev.wv += 69'(fw[k + 32]);
    end
    ev.u    = mu;
    ev.v    = mv;
    ev.kind = (mu < MONT_N && mv < MONT_N) ? K_ACC : K_RANGE;
    ev.cyc  = cyc + 1;
    exp_q.push_back(ev);
  endtask

  task automatic wait_for(input int which, output int t);
    t = 0;
    while (t < 50 && !((which == 0 && op_valid) || (which == 1 && range_err))) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_op_valid"}, op_valid, 1'b0);
    chk({tag, "_errs"}, {range_err, frame_err}, 2'b00);
    chk_wide({tag, "_op_u"}, op_u, '0);
    chk_wide({tag, "_op_v"}, op_v, '0);
    chk({tag, "_op_w"}, {op_wu, op_wv}, '0);
  endtask

  initial begin
    int            t;
    int            cls;
    logic [2047:0] ru;
    logic [2047:0] rv;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    chk("idle_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("load_in_ready", in_ready, 1'b1);

    // u = 5, v = 7 at full rate.
    load_frame(2048'd5, 2048'd7);
    send_frame(-1, -1, 1'b0);
    wait_for(0, t);
    chk("latency_op_valid", t, 1);
    chk_wide("lit_op_u", op_u, 2048'd5);
    chk_wide("lit_op_v", op_v, 2048'd7);
    chk("lit_op_w", {op_wu, op_wv}, {69'd5, 69'd7});

    // u = N-1, v all ones: rejected.
    load_frame(MONT_N - 2048'd1, '1);
    send_frame(-1, -1, 1'b0);
    wait_for(1, t);
    chk("latency_range_err", t, 1);
    chk("range_in_ready", in_ready, 1'b1);
    chk("range_op_valid", op_valid, 1'b0);

    // u = N exactly is out of range; u = N-1 is accepted.
    load_frame(MONT_N, 2048'd3);
    send_frame(-1, -1, 1'b1);
    wait_for(1, t);
    chk("n_equal_rejected", range_err, 1'b1);
    load_frame(MONT_N - 2048'd1, 2048'd3);
    send_frame(-1, -1, 1'b1);
    wait_for(0, t);
    chk("n_minus_1_accepted", op_valid, 1'b1);
    chk("lit_wv_small", op_wv, 69'd3);

    // in_last on beat 10, then a legal frame.
    load_frame(rand_below_n(), rand_below_n());
    send_frame(10, -1, 1'b0);
    chk("frame_err_pulse", frame_err, 1'b1);
    chk("frame_err_in_ready", in_ready, 1'b1);
    send_frame(-1, -1, 1'b0);
    wait_for(0, t);
    chk("after_frame_err_accept", op_valid, 1'b1);

    // in_last missing on beat 63.
    send_frame(63, -1, 1'b1);
    chk("missing_last_pulse", frame_err, 1'b1);

    // Backpressure: hold op_ready low for 20 cycles in PRESENT.
    opr_mode = 2;
    load_frame(rand_below_n(), rand_below_n());
    send_frame(-1, -1, 1'b0);
    wait_for(0, t);
    repeat (20) @(posedge clk);
    #1;
    chk("held_op_valid", op_valid, 1'b1);
    opr_mode = 1;
    @(posedge clk);
    #1;
    chk("released_op_valid", op_valid, 1'b0);
    chk("released_in_ready", in_ready, 1'b1);

    // Reset at beat 40, then a fresh frame.
    load_frame(rand_wide(), rand_wide());
    send_frame(-1, 40, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    reset = 1'b0;
    chk("midreset_idle", in_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("midreset_load", in_ready, 1'b1);
    load_frame(rand_below_n(), 2048'd9);
    send_frame(-1, -1, 1'b1);
    wait_for(0, t);
    chk("post_reset_accept", op_valid, 1'b1);

    // Randomized frames against the model.
    opr_mode = 0;
    for (int f = 0; f < 24; f++) begin
      cls = $urandom_range(0, 3);
      case (cls)
        0: begin
          ru = '0;
          rv = '0;
          ru[255:0] = rand_wide();
          rv[255:0] = rand_wide();
        end
        1: begin
          case ($urandom_range(0, 4))
            0: ru = MONT_N - 2048'd1;
            1: ru = MONT_N;
            2: ru = MONT_N + 2048'd1;
            3: ru = MONT_N - (2048'd1 << (64 * $urandom_range(1, 30)));
            default: ru = MONT_N + (2048'd1 << (64 * $urandom_range(1, 30)));
          endcase
          rv = rand_below_n();
          if ($urandom_range(0, 1) == 1) begin
            rv = ru;
            ru = rand_below_n();
          end
        end
        2: begin
          ru = rand_wide();
          rv = rand_wide();
        end
        default: begin
          ru = rand_below_n();
          rv = rand_below_n();
        end
      endcase
      load_frame(ru, rv);
      send_frame(($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 63)) : -1, -1, 1'b1);
    end

    opr_mode = 1;
    t = 0;
    while ((exp_q.size() > 0 || op_valid) && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
